// File: rtl/axi_wr_slave_ctrl_if.sv
// AXI write-channel bundle (AW, W, B) between a bus master and the write sequencer.
// The slave modport is the view used by axi_wr_slave_ctrl.
interface axi_wr_slave_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          awvalid;
  logic [3:0]    awid;
  logic [AW-1:0] awaddr;
  logic [3:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awready;
  logic          wvalid;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          wready;
  logic          bvalid;
  logic [3:0]    bid;
  logic          bready;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid
  );
endinterface

// File: rtl/axi_wr_slave_ctrl.sv
// Single-outstanding AXI write sequencer: accepts one burst, walks FIXED/INCR/WRAP
// beat addresses onto a word-wide memory write port and returns the B response.
//
// state | meaning
// IDLE  | awready high, waiting for a write request
// DATA  | wready high, one memory write per W handshake
// RESP  | bvalid/bid held until bready
module axi_wr_slave_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  axi_wr_slave_ctrl_if.slave bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  output logic          wlast_err
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t        state_q;
  logic          awready_q;
  logic          wready_q;
  logic          bvalid_q;
  logic [3:0]    bid_q;
  logic [3:0]    id_q;
  logic [3:0]    len_q;
  logic [3:0]    beat_cnt_q;
  logic [1:0]    size_q;
  logic [1:0]    burst_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  logic          w_hs;
  logic          last_beat;
  logic          wrap_ok;
  logic [AW-1:0] incr;
  logic [AW-1:0] base;
  logic [AW-1:0] step_addr;
  logic [AW-1:0] bound_mask;

  assign w_hs      = bus.wvalid & wready_q;
  assign last_beat = (beat_cnt_q == len_q);

  // WRAP only honoured for power-of-two lengths; everything non-FIXED otherwise steps like INCR.
  always_comb begin
    incr       = AW'(1) << size_q;
    base       = addr_q & ~(incr - AW'(1));
    step_addr  = base + incr;
    bound_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    wrap_ok    = (burst_q == 2'd2) &&
                 ((len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15));
    addr_d     = step_addr;
    if (burst_q == 2'd0) begin
      addr_d = addr_q;
    end else if (wrap_ok) begin
      addr_d = (addr_q & ~bound_mask) | (step_addr & bound_mask);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      id_q       <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      addr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          awready_q <= 1'b1;
          if (bus.awvalid && awready_q) begin
            id_q       <= bus.awid;
            len_q      <= bus.awlen;
            size_q     <= (bus.awsize > 3'd2) ? 2'd2 : bus.awsize[1:0];
            burst_q    <= bus.awburst;
            addr_q     <= bus.awaddr;
            beat_cnt_q <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt_q <= beat_cnt_q + 4'd1;
            addr_q     <= addr_d;
            if (last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              state_q  <= RESP;
            end
          end
        end
        RESP: begin
          if (bvalid_q && bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;

  assign mem_we    = w_hs;
  assign mem_addr  = addr_q;
  assign mem_wdata = bus.wdata;
  assign mem_be    = bus.wstrb;
  // wlast is only checked, never used to end the burst early.
  assign wlast_err = w_hs & (bus.wlast != last_beat);

endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
// Bench for axi_wr_slave_ctrl: burst table with explicit beat addresses, scoreboard of
// expected memory writes, plus hand sequences for B backpressure, WLAST errors and reset.
module tb_axi_wr_slave_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        wlast_err;

  axi_wr_slave_ctrl_if #(.AW(32), .DW(32)) bus ();

  axi_wr_slave_ctrl #(.AW(32), .DW(32)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .wlast_err (wlast_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [3:0]       strb;
    logic [7:0][31:0] ex;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  vec_t tbl [12];
  wr_t  exp_q [$];
  wr_t  mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(int i, logic [31:0] addr, logic [3:0] len, logic [2:0] size,
                     logic [1:0] burst, logic [3:0] id, logic [3:0] strb,
                     logic [31:0] a0, logic [31:0] a1, logic [31:0] a2, logic [31:0] a3,
                     logic [31:0] a4, logic [31:0] a5, logic [31:0] a6, logic [31:0] a7);
    tbl[i].addr  = addr;
    tbl[i].len   = len;
    tbl[i].size  = size;
    tbl[i].burst = burst;
    tbl[i].id    = id;
    tbl[i].strb  = strb;
    tbl[i].ex    = {a7, a6, a5, a4, a3, a2, a1, a0};
  endtask

  // Every memory write must match the oldest beat the bench has driven.
  always @(negedge aclk) begin
    if (mem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h t=%0t", mem_addr, mem_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d || mem_be !== mon_e.be) begin
          bad++;
          $display("FAIL mem_write got addr=%h data=%h be=%h exp addr=%h data=%h be=%h",
                   mem_addr, mem_wdata, mem_be, mon_e.a, mon_e.d, mon_e.be);
        end
      end
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_awready"}, bus.awready, 0);
    chk({tag, "_wready"}, bus.wready, 0);
    chk({tag, "_bvalid"}, bus.bvalid, 0);
    chk({tag, "_bid"}, bus.bid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_wlast_err"}, wlast_err, 0);
  endtask

  task automatic set_aw(int idx);
    bus.awid    = tbl[idx].id;
    bus.awaddr  = tbl[idx].addr;
    bus.awlen   = tbl[idx].len;
    bus.awsize  = tbl[idx].size;
    bus.awburst = tbl[idx].burst;
    bus.awvalid = 1'b1;
  endtask

  // Ends #1 after the AW handshake edge, i.e. at the start of the first data cycle.
  task automatic drive_aw(int idx);
    bit seen = 1'b0;
    if (!bus.awvalid) begin
      @(posedge aclk); #1;
      set_aw(idx);
      for (int k = 0; k < 20; k++) begin
        @(negedge aclk);
        if (bus.awready) begin
          seen = 1'b1;
          break;
        end
      end
      chk("aw_accept_timeout", seen, 1);
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic drive_beat(int idx, int b, bit lst);
    wr_t         e;
    logic [31:0] d;
    d = $urandom();
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    bus.wstrb  = tbl[idx].strb;
    bus.wlast  = lst;
    e.a  = tbl[idx].ex[b];
    e.d  = d;
    e.be = tbl[idx].strb;
    exp_q.push_back(e);
    @(negedge aclk);
    chk("wready_beat", bus.wready, 1);
    chk("wlast_err_beat", wlast_err, {31'd0, lst != (b == int'(tbl[idx].len))});
    @(posedge aclk); #1;
  endtask

  task automatic finish_resp(int idx, int bhold, int nxt);
    if (bhold > 0) begin
      set_aw(nxt);
      for (int k = 0; k < bhold; k++) begin
        @(negedge aclk);
        chk("hold_bvalid", bus.bvalid, 1);
        chk("hold_bid", bus.bid, tbl[idx].id);
        chk("hold_awready", bus.awready, 0);
        @(posedge aclk); #1;
      end
      bus.bready = 1'b1;
    end
    @(negedge aclk);
    chk("bvalid_latency", bus.bvalid, 1);
    chk("bid", bus.bid, tbl[idx].id);
    chk("awready_in_resp", bus.awready, 0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("bvalid_drop", bus.bvalid, 0);
    chk("awready_after_b", bus.awready, 1);
  endtask

  task automatic run_burst(int idx, int bhold, int early, int nxt);
    if (bhold > 0) bus.bready = 1'b0;
    drive_aw(idx);
    for (int b = 0; b <= int'(tbl[idx].len); b++)
      drive_beat(idx, b, (early >= 0) ? (b == early) : (b == int'(tbl[idx].len)));
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    finish_resp(idx, bhold, nxt);
  endtask

  initial begin
    //   i  addr          len size burst id strb  beat addresses
    add(0,  32'h100,      3, 2, 1, 5, 4'hF, 32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0);
    add(1,  32'h38,       3, 2, 2, 1, 4'hF, 32'h38, 32'h3C, 32'h30, 32'h34, 0, 0, 0, 0);
    add(2,  32'h203,      2, 0, 0, 2, 4'h8, 32'h203, 32'h203, 32'h203, 0, 0, 0, 0, 0);
    add(3,  32'h103,      3, 1, 1, 3, 4'h3, 32'h103, 32'h104, 32'h106, 32'h108, 0, 0, 0, 0);
    add(4,  32'h1A,       7, 1, 2, 4, 4'hC, 32'h1A, 32'h1C, 32'h1E, 32'h10,
                                             32'h12, 32'h14, 32'h16, 32'h18);
    add(5,  32'h3C,       2, 2, 2, 6, 4'hF, 32'h3C, 32'h40, 32'h44, 0, 0, 0, 0, 0);
    add(6,  32'h10,       1, 2, 3, 7, 4'hF, 32'h10, 32'h14, 0, 0, 0, 0, 0, 0);
    add(7,  32'h20,       1, 5, 1, 8, 4'hF, 32'h20, 32'h24, 0, 0, 0, 0, 0, 0);
    add(8,  32'hFFFFFFF8, 3, 2, 1, 9, 4'hF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 0, 0, 0, 0);
    add(9,  32'h39,       1, 2, 2, 10, 4'h1, 32'h39, 32'h3C, 0, 0, 0, 0, 0, 0);
    add(10, 32'h400,      7, 2, 1, 11, 4'hF, 32'h400, 32'h404, 32'h408, 32'h40C,
                                              32'h410, 32'h414, 32'h418, 32'h41C);
    add(11, 32'h0,        0, 2, 1, 12, 4'hF, 32'h0, 0, 0, 0, 0, 0, 0, 0);

    aresetn     = 1'b0;
    bus.awvalid = 1'b0;
    bus.awid    = '0;
    bus.awaddr  = '0;
    bus.awlen   = '0;
    bus.awsize  = '0;
    bus.awburst = '0;
    bus.wvalid  = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wlast   = 1'b0;
    bus.bready  = 1'b1;

    repeat (2) @(negedge aclk);
    chk_all_zero("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("awready_after_reset", bus.awready, 1);
    chk("wready_idle", bus.wready, 0);

    for (int i = 0; i < 10; i++) run_burst(i, 0, -1, 0);

    // B backpressure with the next request already waiting.
    run_burst(0, 5, -1, 1);
    run_burst(1, 0, -1, 0);

    // wlast on the second beat and missing on the fourth.
    run_burst(3, 0, 1, 0);

    // W traffic while idle must not reach memory.
    @(posedge aclk); #1;
    bus.wvalid = 1'b1;
    bus.wlast  = 1'b1;
    bus.wdata  = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("idle_wready", bus.wready, 0);
      chk("idle_wlast_err", wlast_err, 0);
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;

    // Reset lands on the third beat of an 8-beat burst.
    drive_aw(10);
    drive_beat(10, 0, 1'b0);
    drive_beat(10, 1, 1'b0);
    aresetn    = 1'b0;
    bus.wvalid = 1'b1;
    bus.wdata  = 32'h12345678;
    @(negedge aclk);
    chk_all_zero("midreset");
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("midreset_mem_we", mem_we, 0);
      chk("midreset_bvalid", bus.bvalid, 0);
    end
    @(posedge aclk); #1;
    aresetn    = 1'b1;
    bus.wvalid = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("awready_after_midreset", bus.awready, 1);
    chk("bvalid_after_midreset", bus.bvalid, 0);
    run_burst(11, 0, -1, 0);

    repeat (2) @(negedge aclk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave_ctrl.md
Name: axi_wr_slave_ctrl

Overview:
- Slave-side write-channel sequencer: accepts one AXI write burst at a time on the AW, W and B channels and drives a simple word-wide memory write port.
- Generates per-beat addresses for FIXED, INCR and WRAP bursts.
- Returns the write response and flags a WLAST misplacement.
- Sits between the AXI slave-side bus and an on-chip SRAM or register bank; it is the DUT counterpart the slave agent's memory model mirrors.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed 32 (4 byte strobes).

Ports:
- aclk  input  1  clock, all logic on posedge.
- aresetn  input  1  asynchronous active-low reset.
- awvalid  input  1  write request.
- awid  input  4  write ID.
- awaddr  input  AW  write start address.
- awlen  input  4  beats-1.
- awsize  input  3  0=byte, 1=half, 2=word; >2 is illegal.
- awburst  input  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved.
- awready  output  1  request accept.
- wvalid  input  1  data valid.
- wdata  input  DW  write data.
- wstrb  input  4  byte strobes.
- wlast  input  1  last beat.
- wready  output  1  data accept.
- bvalid  output  1  response valid.
- bid  output  4  response ID.
- bready  input  1  response accept.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory byte address of the current beat.
- mem_wdata  output  DW  equal to wdata.
- mem_be  output  4  equal to wstrb.
- wlast_err  output  1  one-cycle pulse on WLAST/beat-count mismatch.

Behaviour:
- States: IDLE, DATA, RESP. Reset forces IDLE; all registers clear.
- While aresetn is low, all outputs are 0: awready, wready, bvalid, bid, mem_we, mem_addr, wlast_err.
- IDLE:
  - awready=1 (first cycle after reset release onward); wready=0; bvalid=0.
  - On awvalid&awready: capture awid, awaddr, awlen, awsize, awburst; clear beat_cnt; go to DATA next cycle.
  - AW is never accepted outside IDLE, so there is only one outstanding burst.
- DATA:
  - awready=0; wready=1.
  - mem_we = wvalid&wready, combinational. mem_addr = current beat address register. mem_wdata and mem_be pass through combinationally.
  - On each handshake: beat_cnt increments and the address advances.
  - On the handshake where beat_cnt==len: go to RESP.
  - wlast_err pulses in the handshake cycle when wlast != (beat_cnt==len). The burst length always follows awlen; a wlast received early is ignored for sequencing.
- Address step is incr = 1<<size. Base = addr with low size bits cleared.
  - FIXED: address is unchanged.
  - INCR: next = base + incr, modulo 2^AW; wraps silently at the top.
  - WRAP: boundary B = (len+1)*incr; next = (addr & ~(B-1)) | ((base+incr) & (B-1)).
  - WRAP with len not in {1,3,7,15} is treated as INCR. Reserved burst type is treated as INCR.
  - awsize>2 is clamped to 2.
- RESP:
  - bvalid=1 and bid=captured ID, both registered. They hold stable until bready.
  - On bvalid&bready: bvalid drops the next cycle and the FSM goes to IDLE.
  - Earliest new AW acceptance is the cycle after the B handshake.
- Latency: AW handshake at cycle N -> wready=1 at N+1. The last W handshake at cycle M -> bvalid=1 at M+1.
- Back-to-back: wvalid held high gives one beat per cycle with no bubbles.
- Reset mid-burst: everything aborts immediately and asynchronously. No B response is issued, and no mem_we occurs after reset assertion.
- wvalid in IDLE or RESP: ignored, since wready=0. No memory write occurs.

Test Plan:
1. INCR word burst: awaddr=0x100, len=3, size=2, id=5; W beats D0..D3, last beat has wlast.
   -> mem_addr sequence 0x100, 0x104, 0x108, 0x10C; mem_we on 4 cycles; bvalid one cycle after beat 4 with bid=5; wlast_err never pulses.
2. WRAP burst: awaddr=0x38, len=3, size=2.
   -> addresses 0x38, 0x30, 0x34, 0x3C? No, correct sequence is 0x38, 0x3C, 0x30, 0x34 (boundary 16); bvalid after beat 4.
3. FIXED byte burst: awaddr=0x203, len=2, size=0, wstrb=0x8.
   -> mem_addr stays 0x203 for 3 beats; mem_be=0x8 on each beat.
4. bready held low 5 cycles after bvalid, with a new awvalid pending.
   -> bvalid and bid stable for 5 cycles; awready=0 until the cycle after the B handshake, then the new AW is accepted.
5. wlast asserted on beat 2 of a len=3 burst, and not on beat 4.
   -> wlast_err pulses on beat 2 and on beat 4; 4 writes complete; B is issued normally.
6. aresetn deasserted after beat 2 of a len=7 INCR burst.
   -> all outputs 0 immediately; no further mem_we; after release, awready=1 and a fresh len=0 burst at 0x0 completes with bvalid.
